// File: rtl/hazard_pkg.sv
// Opcode ranges, instruction classes and FSM states shared by the hazard controller.
package hazard_pkg;

  localparam logic [5:0] LOAD_LO = 6'h20;
  localparam logic [5:0] LOAD_HI = 6'h27;
  localparam logic [5:0] BR_LO   = 6'h04;
  localparam logic [5:0] BR_HI   = 6'h07;
  localparam logic [5:0] JR0     = 6'h12;
  localparam logic [5:0] JR1     = 6'h13;

  typedef enum logic [2:0] {CLS_ALU, CLS_LOAD, CLS_BR, CLS_JR, CLS_MD} cls_e;
  typedef enum logic {IDLE, BR_WAIT} state_e;

  // The external mul/div decode overrides whatever the opcode range suggests.
  function automatic cls_e classify(input logic [5:0] op, input logic md);
    if (md)                                return CLS_MD;
    if (op >= LOAD_LO && op <= LOAD_HI)    return CLS_LOAD;
    if (op >= BR_LO && op <= BR_HI)        return CLS_BR;
    if (op == JR0 || op == JR1)            return CLS_JR;
    return CLS_ALU;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side bundle between the fetch/decode pipeline and the hazard controller.
interface hazard_ctrl_if #(
  parameter int REG_W = 6,
  parameter int CNT_W = 32
);
  logic             dec_valid;
  logic [0:5]       dec_op;
  logic [REG_W-1:0] dec_rs1;
  logic [REG_W-1:0] dec_rs2;
  logic [REG_W-1:0] dec_rd;
  logic             dec_rd_we;
  logic             dec_md;
  logic             flush;
  logic             pc_stall;
  logic             need_nop;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output dec_valid, dec_op, dec_rs1, dec_rs2, dec_rd, dec_rd_we, dec_md, flush,
    input  pc_stall, need_nop, md_busy, stall_cnt
  );

  modport slave (
    input  dec_valid, dec_op, dec_rs1, dec_rs2, dec_rd, dec_rd_we, dec_md, flush,
    output pc_stall, need_nop, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown of cycles until an in-flight result becomes forwardable.
module hazard_scoreboard #(
  parameter int REG_W = 6,
  parameter int SB_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en_i,
  input  logic [REG_W-1:0] set_idx_i,
  input  logic [SB_W-1:0]  set_val_i,
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic [REG_W-1:0] rd_i,
  output logic             pending_rs1,
  output logic             pending_rs2,
  output logic [SB_W-1:0]  cnt_rd
);

  localparam int NREG = 1 << REG_W;

  logic [SB_W-1:0] cnt_q [NREG];

  // NOTE: this array is reset, unlike a typical RAM, because a stale pending
  // entry after reset would stall the first instruction; keep it in flops.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // counter samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (set_en_i && set_idx_i == REG_W'(i))
          cnt_q[i] <= set_val_i;
        else if (cnt_q[i] != '0)
          cnt_q[i] <= cnt_q[i] - SB_W'(1);
      end
    end
  end

  assign pending_rs1 = (rs1_i != '0) && (cnt_q[rs1_i] != '0);
  assign pending_rs2 = (rs2_i != '0) && (cnt_q[rs2_i] != '0);
  assign cnt_rd      = cnt_q[rd_i];

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: scoreboard, branch-resolve wait, mul/div busy
// tracking and a saturating stall counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W    = 6,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4,
  parameter int BR_LAT   = 1,
  parameter int CNT_W    = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  localparam int MAX_LAT = (LOAD_LAT > MD_LAT) ? LOAD_LAT : MD_LAT;
  localparam int SB_W    = $clog2(MAX_LAT + 1);
  localparam int BR_W    = (BR_LAT > 1) ? $clog2(BR_LAT + 1) : 1;
  localparam logic [SB_W-1:0] LOAD_V = SB_W'(LOAD_LAT);
  localparam logic [SB_W-1:0] MD_V   = SB_W'(MD_LAT);

  cls_e             cls;
  logic             is_br, pend_rs1, pend_rs2, accept, sb_set, pc_stall, need_nop;
  logic             raw_haz, br_haz, waw_haz, md_haz;
  logic [SB_W-1:0]  new_lat, cnt_rd;

  state_e           state_q, state_d;
  logic [BR_W-1:0]  br_cnt_q, br_cnt_d;
  logic [SB_W-1:0]  md_cnt_q, md_cnt_d;
  logic [REG_W-1:0] last_alu_rd_q, last_alu_rd_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign cls   = classify(bus.dec_op, bus.dec_md);
  assign is_br = (cls == CLS_BR) || (cls == CLS_JR);

  always_comb begin
    unique case (cls)
      CLS_LOAD: new_lat = LOAD_V;
      CLS_MD:   new_lat = MD_V;
      default:  new_lat = '0;
    endcase
  end

  hazard_scoreboard #(.REG_W(REG_W), .SB_W(SB_W)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (sb_set),
    .set_idx_i  (bus.dec_rd),
    .set_val_i  (new_lat),
    .rs1_i      (bus.dec_rs1),
    .rs2_i      (bus.dec_rs2),
    .rd_i       (bus.dec_rd),
    .pending_rs1(pend_rs1),
    .pending_rs2(pend_rs2),
    .cnt_rd     (cnt_rd)
  );

  // Branches compare in decode, so a result still in execute cannot reach them.
  assign raw_haz  = bus.dec_valid && (pend_rs1 || pend_rs2);
  assign br_haz   = bus.dec_valid && is_br && (last_alu_rd_q != '0) && (bus.dec_rs1 == last_alu_rd_q);
  assign waw_haz  = bus.dec_valid && bus.dec_rd_we && (cnt_rd > new_lat);
  assign md_haz   = bus.dec_valid && (cls == CLS_MD) && (md_cnt_q != '0);
  assign need_nop = raw_haz || br_haz || waw_haz || md_haz;
  assign pc_stall = need_nop || (state_q == BR_WAIT);

  assign accept = bus.dec_valid && !bus.flush && !pc_stall;
  assign sb_set = accept && bus.dec_rd_we && (bus.dec_rd != '0) && (cls == CLS_LOAD || cls == CLS_MD);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    br_cnt_d = br_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept && is_br && BR_LAT != 0) begin
          state_d  = BR_WAIT;
          br_cnt_d = BR_W'(BR_LAT);
        end
      end
      BR_WAIT: begin
        if (bus.flush || br_cnt_q <= BR_W'(1)) begin
          state_d  = IDLE;
          br_cnt_d = '0;
        end else begin
          br_cnt_d = br_cnt_q - BR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    md_cnt_d = (md_cnt_q != '0) ? md_cnt_q - SB_W'(1) : '0;
    if (accept && cls == CLS_MD) md_cnt_d = MD_V;

    last_alu_rd_d = '0;
    if (accept && cls == CLS_ALU && bus.dec_rd_we) last_alu_rd_d = bus.dec_rd;

    stall_cnt_d = stall_cnt_q;
    if (pc_stall && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      br_cnt_q      <= '0;
      md_cnt_q      <= '0;
      last_alu_rd_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      br_cnt_q      <= br_cnt_d;
      md_cnt_q      <= md_cnt_d;
      last_alu_rd_q <= last_alu_rd_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign bus.pc_stall  = pc_stall;
  assign bus.need_nop  = need_nop;
  assign bus.md_busy   = (md_cnt_q != '0);
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus random traffic against
// a timestamp-based reference model.
module tb_hazard_ctrl;

  localparam int REG_W    = 6;
  localparam int LOAD_LAT = 1;
  localparam int MD_LAT   = 4;
  localparam int BR_LAT   = 1;
  localparam int CNT_W    = 6;
  localparam int NREG     = 1 << REG_W;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) bus ();

  hazard_ctrl #(
    .REG_W(REG_W), .LOAD_LAT(LOAD_LAT), .MD_LAT(MD_LAT), .BR_LAT(BR_LAT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total, bad;

  // Model state as absolute cycle numbers: a register is pending while cyc < rdy[r].
  int rdy [NREG];
  int md_free, br_end, alu_cyc, alu_rd, scnt, cyc;
  bit obs_stall, obs_nop;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int rem_lat(input int r);
    return (r != 0 && rdy[r] > cyc) ? rdy[r] - cyc : 0;
  endfunction

  task automatic model_reset;
    for (int i = 0; i < NREG; i++) rdy[i] = 0;
    md_free = 0; br_end = 0; alu_cyc = -100; alu_rd = 0; scnt = 0;
  endtask

  task automatic drive_idle;
    bus.dec_valid = 0; bus.dec_op = '0; bus.dec_rs1 = '0; bus.dec_rs2 = '0;
    bus.dec_rd = '0; bus.dec_rd_we = 0; bus.dec_md = 0; bus.flush = 0;
  endtask

  // One clock cycle: drive decode, check outputs against the model, advance the model.
  task automatic step(input bit v, input int op, input int rs1, input int rs2, input int rd,
                      input bit we, input bit md, input bit fl);
    bit ld, br, alu, raw, brh, waw, stru, nop, bw, stall, acc, busy;
    int lat, la;
    if (!v) begin op = 0; rs1 = 0; rs2 = 0; rd = 0; we = 0; md = 0; end
    @(negedge clk);
    bus.dec_valid = v;  bus.dec_op = 6'(op);
    bus.dec_rs1 = REG_W'(rs1); bus.dec_rs2 = REG_W'(rs2); bus.dec_rd = REG_W'(rd);
    bus.dec_rd_we = we; bus.dec_md = md; bus.flush = fl;
    #1;
    ld    = !md && op >= 32 && op <= 39;
    br    = !md && ((op >= 4 && op <= 7) || op == 18 || op == 19);
    alu   = !md && !ld && !br;
    lat   = md ? MD_LAT : (ld ? LOAD_LAT : 0);
    la    = (alu_cyc == cyc - 1) ? alu_rd : 0;
    raw   = v && (rem_lat(rs1) > 0 || rem_lat(rs2) > 0);
    brh   = v && br && rs1 != 0 && rs1 == la;
    waw   = v && we && rem_lat(rd) > lat;
    busy  = md_free > cyc;
    stru  = v && md && busy;
    nop   = raw || brh || waw || stru;
    bw    = cyc < br_end;
    stall = nop || bw;
    check("need_nop", bus.need_nop, nop);
    check("pc_stall", bus.pc_stall, stall);
    check("md_busy", bus.md_busy, busy);
    check("stall_cnt", bus.stall_cnt, scnt);
    obs_stall = bus.pc_stall;
    obs_nop   = bus.need_nop;
    acc = v && !fl && !stall;
    if (acc && we && rd != 0 && (md || ld)) rdy[rd] = cyc + 1 + lat;
    if (acc && we && rd != 0 && alu) begin alu_cyc = cyc; alu_rd = rd; end
    if (acc && md) md_free = cyc + 1 + MD_LAT;
    if (acc && br && BR_LAT > 0) br_end = cyc + 1 + BR_LAT;
    if (bw && fl) br_end = cyc + 1;
    if (stall && scnt < SAT) scnt++;
    cyc++;
  endtask

  // Hold one instruction in decode until accepted; compare stall/bubble counts to the plan.
  task automatic issue(input string tag, input int op, input int rs1, input int rs2, input int rd,
                       input bit we, input bit md, input int exp_stalls, input int exp_nops);
    int stalls, nops;
    bit done;
    stalls = 0; nops = 0; done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      step(1, op, rs1, rs2, rd, we, md, 0);
      if (obs_stall) begin
        stalls++;
        if (obs_nop) nops++;
      end else begin
        done = 1;
      end
    end
    check({tag, "/stalls"}, stalls, exp_stalls);
    check({tag, "/nops"}, nops, exp_nops);
  endtask

  // Called right after step(): asserts reset before the next edge, with inputs still live.
  task automatic do_reset;
    #1 rst = 1;
    #1;
    check("rst_need_nop", bus.need_nop, 0);
    check("rst_pc_stall", bus.pc_stall, 0);
    check("rst_md_busy", bus.md_busy, 0);
    check("rst_stall_cnt", bus.stall_cnt, 0);
    drive_idle();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    int r, op;
    total = 0; bad = 0; cyc = 0;
    model_reset();
    drive_idle();
    #1 rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    step(0, 0, 0, 0, 0, 0, 0, 0);

    issue("lw_r3",    'h20, 0, 0, 3, 1, 0, 0, 0);
    issue("load_use", 'h00, 3, 5, 4, 1, 0, 1, 1);
    issue("mul_r7",   'h00, 0, 0, 7, 1, 1, 0, 0);
    issue("mul_r8",   'h00, 0, 0, 8, 1, 1, 4, 4);
    issue("add_r7",   'h00, 7, 0, 9, 1, 0, 0, 0);
    issue("add_r8",   'h00, 8, 0, 10, 1, 0, 3, 3);
    issue("add_r2",   'h00, 0, 0, 2, 1, 0, 0, 0);
    issue("beqz_r2",  'h04, 2, 0, 0, 0, 0, 1, 1);
    issue("beq_ind",  'h05, 10, 0, 0, 0, 0, 1, 0);
    issue("after_br", 'h00, 0, 0, 0, 0, 0, 1, 0);
    issue("mul_r6",   'h00, 0, 0, 6, 1, 1, 0, 0);
    issue("waw_lw",   'h20, 0, 0, 6, 1, 0, 3, 3);
    issue("use_r6",   'h00, 6, 0, 1, 1, 0, 1, 1);
    issue("lw_r0",    'h21, 0, 0, 0, 1, 0, 0, 0);
    issue("use_r0",   'h00, 0, 0, 1, 1, 0, 0, 0);
    step(1, 'h20, 0, 0, 5, 1, 0, 1);
    issue("flushed",  'h00, 5, 0, 6, 1, 0, 0, 0);
    issue("beq_r0",   'h06, 0, 0, 0, 0, 0, 0, 0);
    step(1, 'h00, 0, 0, 11, 1, 0, 1);
    issue("post_fl",  'h00, 0, 0, 12, 1, 0, 0, 0);
    issue("add_r13",  'h00, 0, 0, 13, 1, 0, 0, 0);
    issue("jr_r13",   'h12, 13, 0, 0, 0, 0, 1, 1);
    issue("after_jr", 'h00, 0, 0, 0, 0, 0, 1, 0);
    issue("mul_r3",   'h00, 0, 0, 3, 1, 1, 0, 0);
    issue("gap",      'h00, 0, 0, 0, 0, 0, 0, 0);
    issue("br_ind",   'h07, 0, 0, 0, 0, 0, 0, 0);
    step(1, 'h00, 3, 0, 9, 1, 0, 0);
    do_reset();
    issue("post_rst", 'h00, 3, 0, 4, 1, 0, 0, 0);

    for (int n = 0; n < 2500; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      op = 32 + $urandom_range(0, 7);
      else if (r < 5) op = $urandom_range(4, 7);
      else if (r < 6) op = 18 + $urandom_range(0, 1);
      else            op = $urandom_range(0, 63);
      step($urandom_range(0, 99) < 85, op, $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 7), $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 8);
      if ($urandom_range(0, 599) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
